// File: rtl/x_input_buffer_pkg.sv
// x_input_buffer shared definitions.
// Geometry of the input matrix and FSM state encoding.
package x_input_buffer_pkg;

    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int COLS   = 8;
    localparam int ROW_W  = COLS * DATA_W;
    localparam int NELEM  = ROWS * COLS;
    localparam int CNT_W  = 5;
    localparam int COL_W  = 3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/x_input_buffer_if.sv
// x_input_buffer byte-stream handshake.
// Carries the valid/ready input stream.
interface x_input_buffer_if;
    import x_input_buffer_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/x_row_reg.sv
// x_row_reg: one matrix row.
// Byte write by column index, or rotate left by one element.
module x_row_reg
    import x_input_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rot_en,
    output logic [ROW_W-1:0]  row
);

    // Column 0 sits at the top byte; rotation recirculates it to the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
        end else if (wr_en) begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_col == COL_W'(c)) begin
                    row[ROW_W-1-DATA_W*c -: DATA_W] <= wr_data;
                end
            end
        end else if (rot_en) begin
            row <= {row[ROW_W-DATA_W-1:0], row[ROW_W-1 -: DATA_W]};
        end
    end

endmodule

// File: rtl/x_input_buffer.sv
// x_input_buffer: packs a byte stream into four rows
// and rotates them on ALU request.
module x_input_buffer
    import x_input_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    x_input_buffer_if.slave  in_if,
    input  logic             X_shift,
    input  logic             ALU_done,
    output logic [ROW_W-1:0] X_reg1,
    output logic [ROW_W-1:0] X_reg2,
    output logic [ROW_W-1:0] X_reg3,
    output logic [ROW_W-1:0] X_reg4,
    output logic             buf_full,
    output logic [CNT_W-1:0] rot_cnt,
    output logic             shift_err
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rot_q;
    logic             err_q;
    logic             accept;
    logic             rot_en;
    logic             release_buf;
    logic [ROWS-1:0]  wr_en;
    logic [ROW_W-1:0] rows [ROWS];

    // Next state, handshake and rotate strobe; ALU_done beats X_shift.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        rot_en      = 1'b0;
        release_buf = 1'b0;
        in_if.in_ready = (state_q == LOAD);
        unique case (state_q)
            LOAD: begin
                accept = in_if.in_valid;
                if (accept && cnt_q == CNT_W'(NELEM - 1)) begin
                    state_d = FULL;
                end
            end
            FULL, RUN: begin
                if (ALU_done) begin
                    release_buf = 1'b1;
                    state_d     = LOAD;
                end else if (X_shift) begin
                    rot_en  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Row write enables decoded from the upper counter bits.
    always_comb begin
        wr_en = '0;
        for (int r = 0; r < ROWS; r++) begin
            wr_en[r] = accept && (cnt_q[4:3] == 2'(r));
        end
    end

    // State, byte counter, rotation counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            rot_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (release_buf) begin
                cnt_q <= '0;
                rot_q <= '0;
            end else begin
                if (accept) cnt_q <= cnt_q + 1'b1;
                if (rot_en) rot_q <= rot_q + 1'b1;
            end
            if (state_q == LOAD && X_shift) err_q <= 1'b1;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        x_row_reg u_row (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[r]),
            .wr_col  (cnt_q[2:0]),
            .wr_data (in_if.in_data),
            .rot_en  (rot_en),
            .row     (rows[r])
        );
    end

    assign X_reg1    = rows[0];
    assign X_reg2    = rows[1];
    assign X_reg3    = rows[2];
    assign X_reg4    = rows[3];
    assign buf_full  = (state_q != LOAD);
    assign rot_cnt   = rot_q;
    assign shift_err = err_q;

endmodule

// File: tb/tb_x_input_buffer.sv
// tb_x_input_buffer: randomized and directed checks
// against an array-based matrix model.
module tb_x_input_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        X_shift;
    logic        ALU_done;
    logic [63:0] X_reg1, X_reg2, X_reg3, X_reg4;
    logic        buf_full;
    logic [4:0]  rot_cnt;
    logic        shift_err;
    logic [63:0] xr [4];

    int checks   = 0;
    int failures = 0;

    logic [7:0] xm [4][8];
    int         m_n;
    bit         m_full;
    int         m_rot;
    bit         m_err;

    x_input_buffer_if bus ();

    x_input_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (bus),
        .X_shift   (X_shift),
        .ALU_done  (ALU_done),
        .X_reg1    (X_reg1),
        .X_reg2    (X_reg2),
        .X_reg3    (X_reg3),
        .X_reg4    (X_reg4),
        .buf_full  (buf_full),
        .rot_cnt   (rot_cnt),
        .shift_err (shift_err)
    );

    always #5 clk = ~clk;

    assign xr[0] = X_reg1;
    assign xr[1] = X_reg2;
    assign xr[2] = X_reg3;
    assign xr[3] = X_reg4;

    task automatic m_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                xm[r][c] = 8'h00;
        m_n = 0; m_full = 0; m_rot = 0; m_err = 0;
    endtask

    task automatic m_step(input bit v, input logic [7:0] d,
                          input bit s, input bit a);
        logic [7:0] t;
        if (!m_full) begin
            if (v) begin
                xm[m_n / 8][m_n % 8] = d;
                m_n++;
                if (m_n == 32) begin
                    m_full = 1;
                    m_n = 0;
                end
            end
            if (s) m_err = 1;
        end else if (a) begin
            m_full = 0;
            m_rot = 0;
        end else if (s) begin
            for (int r = 0; r < 4; r++) begin
                t = xm[r][0];
                for (int c = 0; c < 7; c++) xm[r][c] = xm[r][c+1];
                xm[r][7] = t;
            end
            m_rot = (m_rot + 1) % 32;
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[63-8*c -: 8] = xm[r][c];
        return v;
    endfunction

    task automatic step(input bit v, input logic [7:0] d,
                        input bit s, input bit a);
        bus.in_valid = v;
        bus.in_data  = d;
        X_shift      = s;
        ALU_done     = a;
        @(posedge clk);
        m_step(v, d, s, a);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        X_shift      = 1'b0;
        ALU_done     = 1'b0;
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (xr[r] !== 64'h0) begin
                failures++;
                $display("FAIL reset_row%0d got=%h exp=0", r, xr[r]);
            end
        end
        checks++;
        if ({bus.in_ready, buf_full, rot_cnt, shift_err} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags got rdy=%b full=%b rot=%0d err=%b",
                     bus.in_ready, buf_full, rot_cnt, shift_err);
        end
    endtask

    task automatic test_load_seq();
        for (int k = 0; k < 32; k++) begin
            step(1, 8'(k + 1), 0, 0);
            if (k == 30) begin
                checks++;
                if (buf_full !== 1'b0 || bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL load_31 got full=%b rdy=%b exp 0/1",
                             buf_full, bus.in_ready);
                end
            end
        end
        checks++;
        if (X_reg1 !== 64'h0102030405060708) begin
            failures++;
            $display("FAIL load_x1 got=%h exp=0102030405060708", X_reg1);
        end
        checks++;
        if (X_reg4 !== 64'h191A1B1C1D1E1F20) begin
            failures++;
            $display("FAIL load_x4 got=%h exp=191a1b1c1d1e1f20", X_reg4);
        end
        checks++;
        if (buf_full !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_full got full=%b rdy=%b exp 1/0",
                     buf_full, bus.in_ready);
        end
    endtask

    task automatic test_rotate();
        step(0, 0, 1, 0);
        checks++;
        if (X_reg1 !== 64'h0203040506070801 || rot_cnt !== 5'd1) begin
            failures++;
            $display("FAIL rot1 got x1=%h rot=%0d exp 0203040506070801/1",
                     X_reg1, rot_cnt);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        checks++;
        if (X_reg1 !== 64'h0102030405060708 || rot_cnt !== 5'd8) begin
            failures++;
            $display("FAIL rot8 got x1=%h rot=%0d exp 0102030405060708/8",
                     X_reg1, rot_cnt);
        end
        step(0, 0, 0, 0);
        checks++;
        if (rot_cnt !== 5'd8 || X_reg1 !== 64'h0102030405060708) begin
            failures++;
            $display("FAIL rot_hold got x1=%h rot=%0d", X_reg1, rot_cnt);
        end
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        checks++;
        if (rot_cnt !== 5'd0 || X_reg4 !== 64'h191A1B1C1D1E1F20) begin
            failures++;
            $display("FAIL rot32 got x4=%h rot=%0d exp 191a1b1c1d1e1f20/0",
                     X_reg4, rot_cnt);
        end
        step(0, 0, 0, 1);
        checks++;
        if (buf_full !== 1'b0 || bus.in_ready !== 1'b1 || rot_cnt !== 5'd0) begin
            failures++;
            $display("FAIL rot_done got full=%b rdy=%b rot=%0d",
                     buf_full, bus.in_ready, rot_cnt);
        end
    endtask

    task automatic test_random_gaps();
        int acc = 0;
        bit v;
        bit s;
        logic [7:0] d;
        for (int cyc = 0; cyc < 400 && acc < 32; cyc++) begin
            v = ($urandom_range(0, 2) != 0);
            d = 8'($urandom_range(0, 8'hA9));
            if (v) acc++;
            step(v, d, 0, 0);
            checks++;
            if (bus.in_ready !== !m_full) begin
                failures++;
                $display("FAIL gap_ready cyc=%0d got=%b exp=%b",
                         cyc, bus.in_ready, !m_full);
            end
        end
        checks++;
        if (acc < 32) begin
            failures++;
            $display("FAIL gap_timeout got=%0d accepts exp=32", acc);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 8'hAA, 0, 0);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL gap_aa_ready got=%b exp=0", bus.in_ready);
            end
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (xr[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL gap_row%0d got=%h exp=%h", r, xr[r], exp_row(r));
            end
            for (int c = 0; c < 8; c++) begin
                checks++;
                d = xr[r][63-8*c -: 8];
                if (d === 8'hAA) begin
                    failures++;
                    $display("FAIL gap_aa_stored r=%0d c=%0d got=aa", r, c);
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            step($urandom_range(0, 1) != 0, 8'hAA, s, 0);
            checks++;
            if (rot_cnt !== 5'(m_rot) || X_reg2 !== exp_row(1)
                || X_reg3 !== exp_row(2)) begin
                failures++;
                $display("FAIL gap_rot i=%0d got rot=%0d x2=%h exp rot=%0d x2=%h",
                         i, rot_cnt, X_reg2, m_rot, exp_row(1));
            end
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_done_with_shift();
        for (int k = 0; k < 32; k++) step(1, 8'(k + 1), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        checks++;
        if (X_reg1 !== 64'h0405060708010203) begin
            failures++;
            $display("FAIL done_norot got=%h exp=0405060708010203", X_reg1);
        end
        checks++;
        if (buf_full !== 1'b0 || bus.in_ready !== 1'b1 || rot_cnt !== 5'd0) begin
            failures++;
            $display("FAIL done_flags got full=%b rdy=%b rot=%0d",
                     buf_full, bus.in_ready, rot_cnt);
        end
        for (int k = 0; k < 32; k++) step(1, 8'(k + 8'h21), 0, 0);
        checks++;
        if (X_reg1 !== 64'h2122232425262728) begin
            failures++;
            $display("FAIL reload_x1 got=%h exp=2122232425262728", X_reg1);
        end
        checks++;
        if (X_reg4 !== 64'h393A3B3C3D3E3F40) begin
            failures++;
            $display("FAIL reload_x4 got=%h exp=393a3b3c3d3e3f40", X_reg4);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_shift_err();
        for (int k = 0; k < 5; k++) step(1, 8'(k + 8'h51), 0, 0);
        step(0, 0, 1, 0);
        checks++;
        if (shift_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp=1", shift_err);
        end
        checks++;
        if (X_reg1 !== 64'h5152535455262728 || rot_cnt !== 5'd0) begin
            failures++;
            $display("FAIL err_norot got x1=%h rot=%0d exp 5152535455262728/0",
                     X_reg1, rot_cnt);
        end
        for (int k = 5; k < 32; k++) step(1, 8'(k + 8'h51), 0, 0);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (xr[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL err_row%0d got=%h exp=%h", r, xr[r], exp_row(r));
            end
        end
        checks++;
        if (shift_err !== 1'b1 || buf_full !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got err=%b full=%b exp 1/1",
                     shift_err, buf_full);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] first;
        for (int k = 0; k < 20; k++) step(1, 8'($urandom), 0, 0);
        do_reset();
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (xr[r] !== 64'h0) begin
                failures++;
                $display("FAIL rst_mid_row%0d got=%h exp=0", r, xr[r]);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1 || shift_err !== 1'b0 || buf_full !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_flags got rdy=%b err=%b full=%b",
                     bus.in_ready, shift_err, buf_full);
        end
        first = 8'($urandom);
        step(1, first, 0, 0);
        checks++;
        if (X_reg1[63:56] !== first) begin
            failures++;
            $display("FAIL rst_mid_first got=%h exp=%h", X_reg1[63:56], first);
        end
        for (int k = 1; k < 32; k++) step(1, 8'($urandom), 0, 0);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (xr[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL rst_mid_row%0d got=%h exp=%h",
                         r, xr[r], exp_row(r));
            end
        end
        checks++;
        if (buf_full !== m_full) begin
            failures++;
            $display("FAIL rst_mid_full got=%b exp=%b", buf_full, m_full);
        end
    endtask

    initial begin
        test_reset();
        test_load_seq();
        test_rotate();
        test_random_gaps();
        test_done_with_shift();
        test_shift_err();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x_input_buffer.md
Name: x_input_buffer

Overview:
- Upstream feeder for the ALU matrix-multiply stage.
- Accepts the 4x8 input matrix as a byte stream over a valid/ready handshake and packs it into four 64-bit row registers, X_reg1..X_reg4.
- During the multiply it rotates each row left by one element whenever the ALU asserts X_shift, so X_reg[63:56] always presents the current element and each row recirculates for the next coefficient column.
- On ALU_done it releases the buffer and accepts the next matrix.

Parameters:
- DATA_W, 8, element width in bits.
- ROWS, 4, number of row registers.
- COLS, 8, elements per row (row width = COLS*DATA_W = 64).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input element, row-major order.
- in_ready  out  1  buffer accepts in_data this cycle.
- X_shift  in  1  rotate request from the ALU.
- ALU_done  in  1  ALU finished the current matrix.
- X_reg1  out  64  row 0; element at [63:56] is next to be consumed.
- X_reg2  out  64  row 1.
- X_reg3  out  64  row 2.
- X_reg4  out  64  row 3.
- buf_full  out  1  all 32 elements loaded; ALU may start.
- rot_cnt  out  5  rotations performed since the buffer became full.
- shift_err  out  1  sticky flag: X_shift seen while in LOAD.

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values:
  - X_reg1..4 = 0.
  - byte counter = 0.
  - rot_cnt = 0, buf_full = 0, shift_err = 0.
  - state = LOAD, so in_ready = 1 the cycle after reset.
- in_ready is a combinational decode of the state: it is 1 only in LOAD.
- States: LOAD, FULL, RUN.
- LOAD:
  - Accept when in_valid && in_ready.
  - The k-th accepted byte (k = 0..31) goes to row k/8, bits [63-8*(k%8) -: 8]. Other bytes hold.
  - On the accept with k = 31, go to FULL. buf_full = 1 from the next cycle.
  - X_shift asserted in LOAD: no rotation; shift_err is set (sticky until rst).
  - ALU_done in LOAD is ignored.
- FULL:
  - in_ready = 0; in_valid is ignored and never back-pressured into data loss.
  - On X_shift = 1: rotate all four rows left by 8 on that edge (new [7:0] = old [63:56]), rot_cnt += 1, go to RUN.
- RUN:
  - Each rising edge with X_shift = 1 rotates all rows left by 8 and increments rot_cnt modulo 32.
  - After 8 rotations the rows equal the loaded values again; after 32 rotations rot_cnt wraps to 0 with the data back at the original alignment.
  - X_shift = 0 holds the registers.
- ALU_done in FULL or RUN:
  - Go to LOAD next cycle: buf_full = 0, byte counter = 0, rot_cnt = 0.
  - X_reg contents are held; they are not cleared and are overwritten only by new loads.
  - ALU_done and X_shift in the same cycle: ALU_done wins and no rotation occurs.
- Arithmetic:
  - Byte counter is 5-bit (0..31); row index is counter[4:3], column is counter[2:0].
  - rot_cnt is 5-bit wrap-around.
- Latency: the rotated value is visible the cycle after the X_shift edge. Loaded bytes are visible the cycle after accept.
- Reset mid-load or mid-run: full return to reset values. Partial data is discarded and the byte count restarts at 0.

Decomposition:
- Shared package holds:
  - DATA_W, ROWS, COLS.
  - Derived ROW_W = 64 and NELEM = 32.
  - State encoding: LOAD = 2'd0, FULL = 2'd1, RUN = 2'd2.
- One sub-module is natural: x_row_reg, a single 64-bit row with byte-write enable (index, data) and a rotate-left-by-8 enable. It is instantiated ROWS times.
- The top level holds the FSM, counters and the handshake.

Test Plan:
- Load bytes 0x01..0x20 back-to-back with in_valid = 1 -> X_reg1 = 0x0102030405060708, X_reg4 = 0x191A1B1C1D1E1F20; buf_full = 1 and in_ready = 0 one cycle after the 32nd accept.
- After a full load, hold X_shift = 1 for 1 cycle -> X_reg1 = 0x0203040506070801, rot_cnt = 1. For 8 cycles total -> X_reg1 = 0x0102030405060708, rot_cnt = 8. For 32 cycles -> rot_cnt = 0 and data at the original alignment.
- Drive in_valid with random gaps, plus extra bytes 0xAA offered while FULL -> identical final X_reg values; 0xAA is never stored.
- Mid-RUN, assert ALU_done together with X_shift -> no rotation that edge; next cycle buf_full = 0, in_ready = 1, rot_cnt = 0. A new load of 0x21..0x40 gives X_reg1 = 0x2122232425262728.
- Assert X_shift during LOAD after 5 bytes -> shift_err = 1 next cycle and remains 1; no rotation; load still completes correctly.
- Assert rst after 20 accepted bytes -> all X_reg = 0 and in_ready = 1; the next 32 bytes load from row 0, column 0.
